// File: rtl/mul16_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 16x16 multiply controller.
// Partial-product shifts are fixed by the default split point (DEF_SPLIT).
package mul16_seq_ctrl_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_SPLIT   = 7;
  localparam int DEF_MUL_W   = 9;
  localparam int DEF_MUL_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACC,
    DONE
  } state_t;

  typedef logic [1:0] pp_idx_t;

  // Alignment of PP k: low*low, low*high, high*low, high*high.
  localparam int PP_SHIFT [4] = '{0, DEF_SPLIT, DEF_SPLIT, 2 * DEF_SPLIT};

  // Latency counter width; never narrower than one bit so MUL_LAT=0 still elaborates.
  function automatic int lat_cnt_w(input int mul_lat);
    return (mul_lat < 1) ? 1 : $clog2(mul_lat + 1);
  endfunction

endpackage

// File: rtl/mul16_seq_ctrl_if.sv
// Operand/result handshakes plus the shared sub-multiplier port of mul16_seq_ctrl.
// slave is the controller's view; master is the issue stage / multiplier side.
interface mul16_seq_ctrl_if
  import mul16_seq_ctrl_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int MUL_W = DEF_MUL_W
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_a;
  logic [W-1:0]         in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*W-1:0]       out_p;
  logic                 mul_req;
  logic [MUL_W-1:0]     mul_a;
  logic [MUL_W-1:0]     mul_b;
  logic [2*MUL_W-1:0]   mul_p;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_p,
    output in_ready, out_valid, out_p, mul_req, mul_a, mul_b, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_p,
    input  in_ready, out_valid, out_p, mul_req, mul_a, mul_b, busy
  );

endinterface

// File: rtl/mul16_pp_align.sv
// Zero-extends a sub-multiplier product and shifts it to the weight of partial product k.
module mul16_pp_align
  import mul16_seq_ctrl_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int MUL_W = DEF_MUL_W
) (
  input  logic [2*MUL_W-1:0] mul_p,
  input  pp_idx_t            k,
  output logic [2*W-1:0]     addend
);

  logic [2*W-1:0] ext;

  assign ext    = {{(2*W - 2*MUL_W){1'b0}}, mul_p};
  assign addend = ext << PP_SHIFT[k];

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 multiply controller time-sharing one 9x9 sub-multiplier over four partial products.
// Define MUL16_SEQ_CTRL_LL_SKIP_EN to drop the low x low partial product (faster, underestimates).
module mul16_seq_ctrl
  import mul16_seq_ctrl_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SPLIT   = DEF_SPLIT,
  parameter int MUL_W   = DEF_MUL_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input logic             clk,
  input logic             rst,
  mul16_seq_ctrl_if.slave bus
);

  localparam int CNT_W = lat_cnt_w(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

`ifdef MUL16_SEQ_CTRL_LL_SKIP_EN
  localparam pp_idx_t K_FIRST = 2'd1;
`else
  localparam pp_idx_t K_FIRST = 2'd0;
`endif

  state_t           state_q, state_d;
  pp_idx_t          k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   addend;
  logic [MUL_W-1:0] a_h, b_h;
  logic [SPLIT-1:0] a_l, b_l;
  logic             accept;
  logic             do_acc;
  logic             mul_req;

  mul16_pp_align #(
    .W     (W),
    .MUL_W (MUL_W)
  ) u_align (
    .mul_p  (bus.mul_p),
    .k      (k_q),
    .addend (addend)
  );

  // With MUL_LAT=0 the product is ready in the issue cycle, so ISSUE accumulates itself.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    accept  = 1'b0;
    do_acc  = 1'b0;
    mul_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          acc_d   = '0;
          k_d     = K_FIRST;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_req = 1'b1;
        if (MUL_LAT == 0) begin
          do_acc = 1'b1;
        end else if (MUL_LAT > 1) begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end else begin
          state_d = ACC;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACC: begin
        do_acc = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (do_acc) begin
      acc_d = acc_q + addend;
      if (k_q == 2'd3) begin
        state_d = DONE;
      end else begin
        k_d     = k_q + 2'd1;
        state_d = ISSUE;
      end
    end
  end

  always_comb begin
    bus.mul_a = '0;
    bus.mul_b = '0;
    case (k_q)
      2'd0: begin
        bus.mul_a = MUL_W'(a_l);
        bus.mul_b = MUL_W'(b_l);
      end
      2'd1: begin
        bus.mul_a = MUL_W'(a_l);
        bus.mul_b = b_h;
      end
      2'd2: begin
        bus.mul_a = a_h;
        bus.mul_b = MUL_W'(b_l);
      end
      default: begin
        bus.mul_a = a_h;
        bus.mul_b = b_h;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_h     <= '0;
      a_l     <= '0;
      b_h     <= '0;
      b_l     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_h <= bus.in_a[W-1:SPLIT];
        a_l <= bus.in_a[SPLIT-1:0];
        b_h <= bus.in_b[W-1:SPLIT];
        b_l <= bus.in_b[SPLIT-1:0];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_p     = (state_q == DONE) ? acc_q : '0;
  assign bus.mul_req   = mul_req;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Bench for mul16_seq_ctrl: vector table, hand-written corner sequences and random operations
// against a plain-arithmetic product model; honours MUL16_SEQ_CTRL_LL_SKIP_EN when defined.
module tb_mul16_seq_ctrl;

  localparam int MUL_LAT = 1;
`ifdef MUL16_SEQ_CTRL_LL_SKIP_EN
  localparam int N_PP    = 3;
  localparam int K0      = 1;
`else
  localparam int N_PP    = 4;
  localparam int K0      = 0;
`endif
  localparam int EXP_LAT = N_PP * (MUL_LAT + 1) + 1;
  localparam int TIMEOUT = 100;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          accept_cyc;
  int          pair_base;
  logic [17:0] pairs [$];
  logic        req_seen = 1'b0;
  logic [17:0] prod_seen = '0;
  vec_t        vecs [6];

  mul16_seq_ctrl_if #(.W(16), .MUL_W(9)) bus ();

  mul16_seq_ctrl #(
    .W       (16),
    .SPLIT   (7),
    .MUL_W   (9),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact one-cycle sub-multiplier; returns junk whenever no request was issued.
  always @(negedge clk) begin
    req_seen  <= (bus.mul_req === 1'b1);
    prod_seen <= 18'(bus.mul_a) * 18'(bus.mul_b);
    if (bus.mul_req === 1'b1) pairs.push_back({bus.mul_a, bus.mul_b});
  end

  always @(posedge clk) begin
    bus.mul_p <= req_seen ? prod_seen : 18'($urandom);
  end

  function automatic logic [31:0] refProduct(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p;
    p = 64'(a) * 64'(b);
`ifdef MUL16_SEQ_CTRL_LL_SKIP_EN
    p = p - 64'(a[6:0]) * 64'(b[6:0]);
`endif
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (bus.in_ready !== 1'b1 && n < TIMEOUT) begin
      tick();
      n++;
    end
    checkOutput("accept_timeout", 64'(bus.in_ready === 1'b1), 64'd1);
    accept_cyc = cyc;
    pair_base  = pairs.size();
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 16'($urandom);
    bus.in_b     = 16'($urandom);
  endtask

  task automatic waitResult(output logic [31:0] p);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < TIMEOUT) begin
      tick();
      n++;
    end
    checkOutput("result_timeout", 64'(bus.out_valid === 1'b1), 64'd1);
    p = bus.out_p;
  endtask

  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input string name);
    logic [31:0] p;
    bus.out_ready = 1'b1;
    applyStimulus(a, b);
    waitResult(p);
    checkOutput({name, "_p"}, 64'(p), 64'(exp));
    checkOutput({name, "_latency"}, 64'(cyc - accept_cyc), 64'(EXP_LAT));
    checkOutput({name, "_pulses"}, 64'(pairs.size() - pair_base), 64'(N_PP));
    tick();
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] exp;
    logic [15:0] a;
    logic [15:0] b;
    logic [17:0] exp_pairs [4];
    int          stall;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1] = '{16'h0080, 16'h0003, 32'h00000180};
    vecs[2] = '{16'h0000, 16'hBEEF, 32'h00000000};
    vecs[3] = '{16'h0001, 16'h0001, 32'h00000001};
    vecs[4] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[5] = '{16'h1234, 16'h5678, 32'h06260060};
    exp_pairs = '{{9'd0, 9'd3}, {9'd0, 9'd0}, {9'd1, 9'd3}, {9'd1, 9'd0}};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_p", 64'(bus.out_p), 64'd0);
    checkOutput("rst_mul_req", 64'(bus.mul_req), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_mul_a", 64'(bus.mul_a), 64'd0);
    checkOutput("rst_mul_b", 64'(bus.mul_b), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      exp = vecs[i].p;
`ifdef MUL16_SEQ_CTRL_LL_SKIP_EN
      exp = exp - 32'(vecs[i].a[6:0]) * 32'(vecs[i].b[6:0]);
`endif
      runOp(vecs[i].a, vecs[i].b, exp, $sformatf("vec%0d", i));
      if (i == 1) begin
        for (int j = K0; j < 4; j++) begin
          checkOutput($sformatf("issue_order%0d", j), 64'(pairs[pair_base + j - K0]),
                      64'(exp_pairs[j]));
        end
      end
    end

    // Backpressure: result must hold and new operands must be ignored until released.
    a = 16'h4321;
    b = 16'h00FF;
    exp = refProduct(a, b);
    bus.out_ready = 1'b0;
    applyStimulus(a, b);
    waitResult(p);
    checkOutput("bp_p", 64'(p), 64'(exp));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      tick();
      checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_hold_p", 64'(bus.out_p), 64'(exp));
      checkOutput("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_hold_busy", 64'(bus.busy), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    runOp(16'h0F0F, 16'hF00D, refProduct(16'h0F0F, 16'hF00D), "bp_next");

    // Reset four cycles into an operation aborts it with no result.
    applyStimulus(16'hABCD, 16'h1234);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_mul_req", 64'(bus.mul_req), 64'd0);
    runOp(16'd2, 16'd3, refProduct(16'd2, 16'd3), "post_rst");

    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp = refProduct(a, b);
      bus.out_ready = 1'($urandom_range(0, 1));
      applyStimulus(a, b);
      waitResult(p);
      checkOutput($sformatf("rnd%0d_p", i), 64'(p), 64'(exp));
      if (bus.out_ready == 1'b0) begin
        stall = $urandom_range(1, 3);
        repeat (stall) tick();
        checkOutput($sformatf("rnd%0d_stall_p", i), 64'(bus.out_p), 64'(exp));
      end
      bus.out_ready = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
